regfile_alu_pipe: RTL and testbench
===================================

Name: regfile_alu_pipe

Overview:
- Parametrised successor to the single-shot register-file/ALU datapath.
- Accepts one operation per cycle over a valid/ready handshake. Reads two operands from an internal register file and computes one of eight ALU functions.
- Holds the result in an output stage. Writes the result back to the register file when the consumer accepts it.
- Adds backpressure, write-back forwarding, a preload port, a zero flag and an optional hardwired-zero register.

Parameters:
- DATA_W, 32, operand/result width in bits (>= 8, power of two).
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 always reads 0 and writes to it are discarded.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept an operation this cycle.
- ra  in  ADDR_W  operand A source register.
- rb  in  ADDR_W  operand B source register.
- rw  in  ADDR_W  destination register.
- op  in  3  ALU function select.
- out_valid  out  1  result stage holds a result.
- out_ready  in  1  consumer accepts result.
- out_a  out  DATA_W  operand A used for held result.
- out_b  out  DATA_W  operand B used for held result.
- out_w  out  DATA_W  held result.
- out_rw  out  ADDR_W  destination of held result.
- out_zero  out  1  out_w == 0.
- ld_en  in  1  preload write enable.
- ld_addr  in  ADDR_W  preload address.
- ld_data  in  DATA_W  preload data.

Behaviour:
- Reset (async, rst_n=0): all registers = 0; out_valid=0; out_a/out_b/out_w/out_rw=0; out_zero=1. Reset mid-operation discards the held result with no write-back. First accept is possible in the cycle after rst_n rises.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- On accept:
  - Operands are read, the result is computed, and out_a/out_b/out_w/out_rw/out_zero are registered. out_valid=1 next cycle.
  - Latency: 1 cycle from accept to out_valid.
- Retire = out_valid && out_ready.
  - On retire, out_w is written to register out_rw at the same edge.
  - Retire without a same-cycle accept makes out_valid=0 next cycle.
- Holding: while out_valid=1 and out_ready=0, all out_* are stable and in_ready=0.
- Forwarding: a read sees register contents from before the edge, with one exception. If a retire occurs in the same cycle and ra (or rb) == out_rw, out_w is used instead. Back-to-back dependent operations therefore get the correct value with no bubble.
- ZERO_REG=1:
  - Reads of address 0 return 0, including forwarded values.
  - Retire or load writes to address 0 are dropped.
- ALU ops:
  - 000 ADD and 001 SUB: modulo 2**DATA_W, no carry output.
  - 010 AND, 011 OR, 100 XOR.
  - 101 SLT: signed A<B gives 1, else 0, zero-extended.
  - 110 SLL by B[log2(DATA_W)-1:0].
  - 111 SRL (logical) by the same shift amount.
- Preload:
  - ld_en writes ld_data to ld_addr at the edge, independent of the handshake.
  - A load is not visible to a read in the same cycle (no forwarding from ld).
  - If a load and a retire target the same address in one cycle, the retire wins.
- Multiple register-file writes per cycle are limited to one retire plus one load at distinct addresses.

Test Plan:
- Reset with out_ready=0, then ld r1=5, ld r2=3. Issue ADD ra=1 rb=2 rw=3 -> next cycle out_valid=1, out_w=8, out_zero=0. Set out_ready=1 -> r3=8.
- Back-to-back with out_ready=1: SUB r4=r3-r1, then XOR r5=r4^r4 the next cycle -> out_w=3, then out_w=0 with out_zero=1. No bubble; in_ready stays 1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable throughout. Release -> exactly one retire, then the next accept.
- ZERO_REG: ld r0=0xFFFF, then ADD rw=0 ra=1 rb=1 and retire -> subsequent read of r0 gives out_a=0.
- Ops with DATA_W=32:
  - SLT with A=0xFFFFFFFF, B=1 -> 1.
  - SRL with A=0x80000000, B=31 -> 1.
  - SLL with A=1, B=0x21 -> 2 (shift amount masked).
  - SUB 0-1 -> 0xFFFFFFFF.
- Collision and reset:
  - ld_en to r6 in the same cycle as a retire to r6 -> r6 holds the retired value.
  - Assert rst_n=0 while out_valid=1 -> out_valid=0 immediately, destination not written.

Source files
------------

// File: rtl/regfile_alu_pipe.sv
// Register file feeding an 8-function ALU with a single valid/ready result stage.
// Results write back on retire and are forwarded to same-cycle operand reads.
module regfile_alu_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rw,
  input  logic [2:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_w,
  output logic [ADDR_W-1:0] out_rw,
  output logic              out_zero,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int SH_W  = $clog2(DATA_W);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] a_val, b_val, res;
  logic [SH_W-1:0]   shamt;
  logic              accept, retire, ra_zero, rb_zero, rw_zero, ld_zero;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready;

  assign ra_zero = (ZERO_REG != 0) && (ra == '0);
  assign rb_zero = (ZERO_REG != 0) && (rb == '0);
  assign rw_zero = (ZERO_REG != 0) && (out_rw == '0);
  assign ld_zero = (ZERO_REG != 0) && (ld_addr == '0);

  // Retiring value bypasses the array so a dependent op needs no bubble.
  always_comb begin
    a_val = regs[ra];
    b_val = regs[rb];
    if (retire && ra == out_rw) a_val = out_w;
    if (retire && rb == out_rw) b_val = out_w;
    if (ra_zero) a_val = '0;
    if (rb_zero) b_val = '0;
  end

  assign shamt = b_val[SH_W-1:0];

  always_comb begin
    res = '0;
    case (op)
      3'd0: res = a_val + b_val;
      3'd1: res = a_val - b_val;
      3'd2: res = a_val & b_val;
      3'd3: res = a_val | b_val;
      3'd4: res = a_val ^ b_val;
      3'd5: res = {{(DATA_W-1){1'b0}}, $signed(a_val) < $signed(b_val)};
      3'd6: res = a_val << shamt;
      3'd7: res = a_val >> shamt;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_w     <= '0;
      out_rw    <= '0;
      out_zero  <= 1'b1;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_a     <= a_val;
        out_b     <= b_val;
        out_w     <= res;
        out_rw    <= rw;
        out_zero  <= (res == '0);
      end else if (retire) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Retire has priority over a preload to the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (ld_en && !ld_zero && !(retire && ld_addr == out_rw))
        regs[ld_addr] <= ld_data;
      if (retire && !rw_zero)
        regs[out_rw] <= out_w;
    end
  end
endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Randomized and directed bench against a register-array reference model.
module tb_regfile_alu_pipe;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_zero, ld_en;
  logic [AW-1:0] ra, rb, rw, out_rw, ld_addr;
  logic [2:0]    op;
  logic [DW-1:0] out_a, out_b, out_w, ld_data;

  regfile_alu_pipe #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ra(ra), .rb(rb), .rw(rw), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_w(out_w),
    .out_rw(out_rw), .out_zero(out_zero), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [DW-1:0] mreg [16];
  logic          m_valid;
  logic [DW-1:0] m_a, m_b, m_w;
  logic [AW-1:0] m_rw;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] alu(input logic [2:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sa;
    sa = int'(b % DW);
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd6: return a << sa;
      default: return a >> sa;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = '0;
    m_valid = 0; m_a = '0; m_b = '0; m_w = '0; m_rw = '0;
  endtask

  // One clock of architectural behaviour: retire commits first, operands see that,
  // then the preload lands unless the retire claimed the same register.
  task automatic model_step();
    logic [DW-1:0] nr [16];
    logic          ret, acc;
    logic [DW-1:0] a, b;
    logic [AW-1:0] old_rw;
    ret = m_valid && out_ready;
    acc = in_valid && (!m_valid || out_ready);
    old_rw = m_rw;
    nr = mreg;
    if (ret && m_rw != 0) nr[m_rw] = m_w;
    if (acc) begin
      a = (ra == 0) ? '0 : nr[ra];
      b = (rb == 0) ? '0 : nr[rb];
      m_a = a; m_b = b; m_w = alu(op, a, b); m_rw = rw; m_valid = 1;
    end else if (ret) m_valid = 0;
    mreg = nr;
    if (ld_en && ld_addr != 0 && !(ret && ld_addr == old_rw)) mreg[ld_addr] = ld_data;
  endtask

  task automatic check_outs();
    chk("out_valid", DW'(out_valid), DW'(m_valid));
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_w", out_w, m_w);
    chk("out_rw", DW'(out_rw), DW'(m_rw));
    chk("out_zero", DW'(out_zero), DW'(m_w == 0));
  endtask

  // Called at a negedge: drive, check in_ready, advance model, check at next negedge.
  task automatic go(input logic iv, input int a, input int b, input int w, input int f,
                    input logic ordy, input logic le, input int la, input logic [DW-1:0] ld);
    in_valid = iv; ra = AW'(a); rb = AW'(b); rw = AW'(w); op = 3'(f);
    out_ready = ordy; ld_en = le; ld_addr = AW'(la); ld_data = ld;
    #1;
    chk("in_ready", DW'(in_ready), DW'(!m_valid || ordy));
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle(input logic ordy);
    go(0, 0, 0, 0, 0, ordy, 0, 0, '0);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; ra = '0; rb = '0; rw = '0; op = '0;
    out_ready = 0; ld_en = 0; ld_addr = '0; ld_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs();
    chk("rst_in_ready", DW'(in_ready), 1);
    rst_n = 1;

    // basic add and retire
    go(0, 0, 0, 0, 0, 0, 1, 1, 5);
    go(0, 0, 0, 0, 0, 0, 1, 2, 3);
    go(1, 1, 2, 3, 0, 0, 0, 0, '0);
    chk("add", out_w, 8);
    chk("add_zero", DW'(out_zero), 0);
    idle(1);

    // dependent back-to-back
    go(1, 3, 1, 4, 1, 1, 0, 0, '0);
    chk("sub", out_w, 3);
    go(1, 4, 4, 5, 4, 1, 0, 0, '0);
    chk("xor_fwd", out_w, 0);
    chk("xor_zero", DW'(out_zero), 1);
    idle(1);

    // backpressure
    go(1, 1, 1, 6, 0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      go(1, 2, 2, 7, 0, 0, 0, 0, '0);
      chk("bp_hold", out_w, 10);
      chk("bp_rdy", DW'(in_ready), 0);
    end
    go(1, 2, 2, 7, 0, 1, 0, 0, '0);
    chk("bp_next", out_w, 6);
    idle(1);

    // hardwired zero register
    go(0, 0, 0, 0, 0, 1, 1, 0, 32'hFFFF);
    go(1, 1, 1, 0, 0, 1, 0, 0, '0);
    go(1, 0, 1, 7, 0, 1, 0, 0, '0);
    chk("r0_fwd", out_a, 0);
    idle(1);
    go(1, 0, 1, 7, 0, 1, 0, 0, '0);
    chk("r0_read", out_a, 0);
    idle(1);

    // op corners
    go(0, 0, 0, 0, 0, 1, 1, 8, 32'hFFFFFFFF);
    go(0, 0, 0, 0, 0, 1, 1, 9, 1);
    go(0, 0, 0, 0, 0, 1, 1, 10, 32'h80000000);
    go(0, 0, 0, 0, 0, 1, 1, 11, 31);
    go(0, 0, 0, 0, 0, 1, 1, 12, 32'h21);
    go(1, 8, 9, 13, 5, 1, 0, 0, '0);
    chk("slt", out_w, 1);
    go(1, 10, 11, 13, 7, 1, 0, 0, '0);
    chk("srl", out_w, 1);
    go(1, 9, 12, 13, 6, 1, 0, 0, '0);
    chk("sll", out_w, 2);
    go(1, 0, 9, 13, 1, 1, 0, 0, '0);
    chk("sub_wrap", out_w, 32'hFFFFFFFF);
    idle(1);

    // load/retire collision
    go(1, 9, 9, 6, 0, 0, 0, 0, '0);
    go(0, 0, 0, 0, 0, 1, 1, 6, 32'h55);
    go(1, 6, 0, 13, 0, 1, 0, 0, '0);
    chk("collide", out_a, 2);
    idle(1);

    // async reset while holding a result
    go(1, 9, 9, 14, 0, 0, 0, 0, '0);
    rst_n = 0;
    #1;
    chk("rst_valid", DW'(out_valid), 0);
    chk("rst_zero", DW'(out_zero), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    go(1, 14, 9, 1, 0, 1, 0, 0, '0);
    chk("rst_regs", out_a, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [DW-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : $urandom;
      go($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
         $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 9) < 7,
         $urandom_range(0, 2) == 0, $urandom_range(0, 15), d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
